// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with busy scoreboard.
package regfile_pkg;

  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);
  localparam int ZERO_REG  = 0;

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] data_word_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: data and busy lookup, with write-to-read
// forwarding when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]         rs,
  input  logic [NREGS*XLEN-1:0] regs,
  input  logic [NREGS-1:0]      busy_bits,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  output logic [XLEN-1:0]       data,
  output logic                  busy
);

  logic rs_zero;
  assign rs_zero = (rs == AW'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
  // rs is nonzero whenever fwd is set, so wr_addr is nonzero too.
  logic fwd;
  assign fwd = wr_en && (wr_addr == rs) && !rs_zero;

  always_comb begin
    data = '0;
    busy = 1'b0;
    if (!rs_zero) begin
      if (fwd) begin
        data = wr_data;
        // A same-cycle issue to this register keeps the old busy state visible.
        busy = (iss_valid && (iss_addr == wr_addr)) ? busy_bits[rs] : 1'b0;
      end else begin
        data = regs[int'(rs)*XLEN +: XLEN];
        busy = busy_bits[rs];
      end
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data, iss_valid, iss_addr};

  always_comb begin
    data = '0;
    busy = 1'b0;
    if (!rs_zero) begin
      data = regs[int'(rs)*XLEN +: XLEN];
      busy = busy_bits[rs];
    end
  end
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register busy scoreboard and flush.
// Optional macro REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rs,
  output logic [NREAD*XLEN-1:0] Read_Data,
  output logic [NREAD-1:0]      busy,
  input  logic [AW-1:0]         rd,
  input  logic                  Reg_Write,
  input  logic [XLEN-1:0]       Write_Data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  flush
);

  logic [NREGS*XLEN-1:0] regs_flat;
  logic [NREGS-1:0]      busy_flat;
  logic                  wr_en;

  assign wr_en = Reg_Write && (rd != AW'(ZERO_REG));

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_row
      if (gi == ZERO_REG) begin : g_zero
        assign regs_flat[gi*XLEN +: XLEN] = '0;
        assign busy_flat[gi]              = 1'b0;
      end else begin : g_live
        logic [XLEN-1:0] data_reg;
        logic            busy_reg;
        logic            wr_sel;
        logic            iss_sel;

        assign wr_sel  = Reg_Write && (rd == AW'(gi));
        assign iss_sel = issue_valid && (issue_rd == AW'(gi));

        // Issue beats writeback and flush: the newest producer owns the register.
        always_ff @(posedge clk) begin
          if (!reset) begin
            data_reg <= '0;
            busy_reg <= 1'b0;
          end else begin
            if (wr_sel)
              data_reg <= Write_Data;
            if (iss_sel)
              busy_reg <= 1'b1;
            else if (wr_sel || flush)
              busy_reg <= 1'b0;
          end
        end

        assign regs_flat[gi*XLEN +: XLEN] = data_reg;
        assign busy_flat[gi]              = busy_reg;
      end
    end

    for (gi = 0; gi < NREAD; gi++) begin : g_port
      regfile_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
      ) u_port (
        .rs        (rs[gi*AW +: AW]),
        .regs      (regs_flat),
        .busy_bits (busy_flat),
        .wr_en     (wr_en),
        .wr_addr   (rd),
        .wr_data   (Write_Data),
        .iss_valid (issue_valid),
        .iss_addr  (issue_rd),
        .data      (Read_Data[gi*XLEN +: XLEN]),
        .busy      (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed check of regfile_scoreboard against an array model;
// a second instance covers XLEN=32, NREGS=16, NREAD=3.
module tb_regfile_scoreboard;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [NREAD*AW-1:0]   rs;
  logic [NREAD*XLEN-1:0] Read_Data;
  logic [NREAD-1:0]      busy;
  logic [AW-1:0]         rd;
  logic                  Reg_Write;
  logic [XLEN-1:0]       Write_Data;
  logic                  issue_valid;
  logic [AW-1:0]         issue_rd;
  logic                  flush;

  logic        s_reset;
  logic [11:0] s_rs;
  logic [95:0] s_Read_Data;
  logic [2:0]  s_busy;
  logic [3:0]  s_rd;
  logic        s_Reg_Write;
  logic [31:0] s_Write_Data;
  logic        s_issue_valid;
  logic [3:0]  s_issue_rd;
  logic        s_flush;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk(clk), .reset(reset), .rs(rs), .Read_Data(Read_Data), .busy(busy),
    .rd(rd), .Reg_Write(Reg_Write), .Write_Data(Write_Data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(16), .NREAD(3)) dut_small (
    .clk(clk), .reset(s_reset), .rs(s_rs), .Read_Data(s_Read_Data), .busy(s_busy),
    .rd(s_rd), .Reg_Write(s_Reg_Write), .Write_Data(s_Write_Data),
    .issue_valid(s_issue_valid), .issue_rd(s_issue_rd), .flush(s_flush)
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [XLEN-1:0] mdl_data [NREGS];
  logic            mdl_busy [NREGS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (Reg_Write && rd != 0 && a == rd) return Write_Data;
`endif
    return mdl_data[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (Reg_Write && rd != 0 && a == rd)
      return (issue_valid && issue_rd == rd) ? mdl_busy[a] : 1'b0;
`endif
    return mdl_busy[a];
  endfunction

  task automatic do_cycle(input logic rst, input logic wr, input logic [AW-1:0] wa,
                          input logic [63:0] wd, input logic iv, input logic [AW-1:0] ia,
                          input logic fl, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(negedge clk);
    reset = rst; Reg_Write = wr; rd = wa; Write_Data = wd;
    issue_valid = iv; issue_rd = ia; flush = fl; rs = {r1, r0};
    #1;
    $display("txn %0d rst=%b wr=%b rd=%0d wd=%h iv=%b ird=%0d fl=%b rs0=%0d rs1=%0d",
             txn, rst, wr, wa, wd, iv, ia, fl, r0, r1);
    txn++;
    check("rdata0", Read_Data[63:0], exp_data(r0));
    check("rdata1", Read_Data[127:64], exp_data(r1));
    check("busy0", {63'b0, busy[0]}, {63'b0, exp_busy(r0)});
    check("busy1", {63'b0, busy[1]}, {63'b0, exp_busy(r1)});
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mdl_data[i] = '0;
        mdl_busy[i] = 1'b0;
      end
    end else begin
      if (wr && wa != 0) mdl_data[wa] = wd;
      if (fl) for (int i = 0; i < NREGS; i++) mdl_busy[i] = 1'b0;
      if (wr && wa != 0) mdl_busy[wa] = 1'b0;
      if (iv && ia != 0) mdl_busy[ia] = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b0; Reg_Write = 1'b0; rd = '0; Write_Data = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0; rs = '0;
    s_reset = 1'b0; s_Reg_Write = 1'b0; s_rd = '0; s_Write_Data = '0;
    s_issue_valid = 1'b0; s_issue_rd = '0; s_flush = 1'b0; s_rs = '0;
    for (int i = 0; i < NREGS; i++) begin
      mdl_data[i] = '0;
      mdl_busy[i] = 1'b0;
    end
    repeat (2) @(posedge clk);

    // reset clears writes and beats a same-edge write/issue
    do_cycle(1, 1, 3, 64'd1, 0, 0, 0, 0, 0);
    do_cycle(1, 1, 9, 64'd1, 1, 9, 0, 3, 0);
    do_cycle(1, 0, 0, 64'd0, 0, 0, 0, 3, 9);
    do_cycle(0, 1, 5, 64'h55, 1, 5, 0, 3, 9);
    do_cycle(1, 0, 0, 64'd0, 0, 0, 0, 5, 3);
    do_cycle(1, 0, 0, 64'd0, 0, 0, 0, 9, 0);
    // write/read and x0
    do_cycle(1, 1, 2, 64'd1, 0, 0, 0, 2, 0);
    do_cycle(1, 1, 0, 64'hDEADBEEF, 1, 0, 0, 2, 0);
    do_cycle(1, 0, 0, 64'd0, 0, 0, 0, 2, 2);
    // scoreboard set and clear
    do_cycle(1, 0, 0, 64'd0, 1, 6, 0, 6, 0);
    do_cycle(1, 1, 6, 64'd5, 0, 0, 0, 6, 6);
    do_cycle(1, 0, 0, 64'd0, 0, 0, 0, 6, 6);
    // simultaneous issue+writeback, then flush+issue
    do_cycle(1, 0, 0, 64'd0, 1, 6, 0, 6, 0);
    do_cycle(1, 1, 6, 64'd9, 1, 6, 0, 6, 0);
    do_cycle(1, 1, 6, 64'd11, 1, 7, 1, 6, 7);
    do_cycle(1, 0, 0, 64'd0, 0, 0, 0, 6, 7);
    // forwarding window
    do_cycle(1, 1, 1, 64'd1, 0, 0, 0, 1, 0);
    do_cycle(1, 0, 0, 64'd0, 0, 0, 0, 1, 0);

    for (int n = 0; n < 400; n++) begin
      logic [63:0] wd;
      wd = {$urandom, $urandom};
      do_cycle($urandom_range(0, 49) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
               wd, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
               $urandom_range(0, 7) == 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    // narrow configuration: top register, no wrap onto x0
    @(negedge clk);
    s_reset = 1'b1; s_rs = {4'd15, 4'd0, 4'd15};
    #1;
    check("small_reset0", {32'b0, s_Read_Data[31:0]}, 64'd0);
    check("small_busy_reset", {61'b0, s_busy}, 64'd0);
    @(negedge clk);
    s_Reg_Write = 1'b1; s_rd = 4'd15; s_Write_Data = 32'hFFFFFFFF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("small_fwd", {32'b0, s_Read_Data[31:0]}, 64'hFFFFFFFF);
`else
    check("small_prewrite", {32'b0, s_Read_Data[31:0]}, 64'd0);
`endif
    @(negedge clk);
    s_Reg_Write = 1'b0; s_issue_valid = 1'b1; s_issue_rd = 4'd15;
    #1;
    check("small_p0", {32'b0, s_Read_Data[31:0]}, 64'hFFFFFFFF);
    check("small_p1", {32'b0, s_Read_Data[63:32]}, 64'd0);
    check("small_p2", {32'b0, s_Read_Data[95:64]}, 64'hFFFFFFFF);
    @(negedge clk);
    s_issue_valid = 1'b0;
    #1;
    check("small_busy", {61'b0, s_busy}, 64'd5);
    @(negedge clk);
    s_flush = 1'b1;
    @(negedge clk);
    s_flush = 1'b0;
    #1;
    check("small_flush", {61'b0, s_busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
